// File: rtl/exc_pkg.sv
// rtl/exc_pkg.sv - shared types, cause codes and code helper for exc_ctrl
package exc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        HANDLER = 2'd2
    } state_t;

    localparam logic [3:0] ES_NONE  = 4'h0;
    localparam logic [3:0] ES_INVOP = 4'h1;

    // Cause code reported for pending index; the external IRQ sits at index NSRC
    function automatic logic [3:0] code_of(input int index);
        return 4'(index + 1);
    endfunction

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - 2-flop synchronizer with rising-edge pulse output
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic meta_q;
    logic sync_q;
    logic dly_q;

    // Two synchronizer stages followed by a delayed copy for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            dly_q  <= 1'b0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            dly_q  <= sync_q;
        end
    end

    assign pulse = sync_q & ~dly_q;

endmodule

// File: rtl/exc_ctrl.sv
// rtl/exc_ctrl.sv - exception/interrupt request generator with handler tracking
module exc_ctrl
    import exc_pkg::*;
#(
    parameter int NSRC = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] exc_src,
    input  logic            ext_irq,
    input  logic            irq_en,
    input  logic            ExcAck,
    input  logic            ERet,
    output logic            Exc,
    output logic [3:0]      EStatus,
    output logic            in_handler,
    output logic [NSRC:0]   pending
);

    state_t        state_q;
    state_t        state_d;
    logic [3:0]    estatus_d;
    logic          irq_pulse;
    logic          take;
    logic [NSRC:0] eff;
    logic [NSRC:0] set_mask;
    logic [NSRC:0] clr_mask;
    logic [NSRC:0] pending_d;
    logic [3:0]    win_code;

    sync_edge u_irq_sync (
        .clk   (clk),
        .rst   (reset),
        .din   (ext_irq),
        .pulse (irq_pulse)
    );

    // The enable gates only which pending bits may be selected, never latching
    assign eff      = pending & {irq_en, {NSRC{1'b1}}};
    assign set_mask = {irq_pulse, exc_src};
    assign take     = (state_q == REQUEST) && ExcAck;

    // Lowest set index of eff wins; scan from the top so the lowest overwrites
    always_comb begin
        win_code = ES_NONE;
        for (int i = NSRC; i >= 0; i--) begin
            if (eff[i]) win_code = code_of(i);
        end
    end

    // The winner is recovered from the held EStatus, so late arrivals cannot retarget the clear
    always_comb begin
        clr_mask = '0;
        for (int i = 0; i <= NSRC; i++) begin
            clr_mask[i] = take && (EStatus == code_of(i));
        end
    end

    // Set is applied after clear so an event coinciding with its own ack is kept
    assign pending_d = (pending & ~clr_mask) | set_mask;

    // Next-state and cause-code selection for the request/handler handshake
    always_comb begin
        state_d   = state_q;
        estatus_d = EStatus;
        case (state_q)
            IDLE: begin
                if (|eff) begin
                    state_d   = REQUEST;
                    estatus_d = win_code;
                end
            end
            REQUEST: begin
                if (ExcAck) state_d = HANDLER;
            end
            HANDLER: begin
                if (ERet) begin
                    state_d   = IDLE;
                    estatus_d = ES_NONE;
                end
            end
            default: begin
                state_d   = IDLE;
                estatus_d = ES_NONE;
            end
        endcase
    end

    // State, cause code and sticky pending bits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            EStatus <= ES_NONE;
            pending <= '0;
        end else begin
            state_q <= state_d;
            EStatus <= estatus_d;
            pending <= pending_d;
        end
    end

    assign Exc        = (state_q == REQUEST);
    assign in_handler = (state_q == HANDLER);

endmodule
